// File: rtl/term_inj_arbiter.sv
// rtl/term_inj_arbiter.sv - round-robin burst arbiter feeding one mesh terminal input port
//
// Several requester FIFOs (first-word-fall-through) share one mesh terminal input.
// A round-robin FSM grants one requester at a time for up to MAX_BURST packets.
// Packets pass through a one-entry output register toward the mesh.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   req_pndng      per-requester non-empty flags
//   req_data       per-requester head packets, slice i = [i*PCKG_SZ +: PCKG_SZ]
//   req_pop        one-hot-or-zero pop strobe back to the requesters (combinational)
//   data_out_i_in  registered packet toward the mesh
//   pndng_i_in     registered valid toward the mesh
//   popin          mesh consumed the presented packet this cycle
//   grant_id       index of the current or last granted requester
//   grant_cnt      (ARB_STATS_EN only) per-requester 16-bit saturating load counters
//
// Optional feature macro: ARB_STATS_EN
module term_inj_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PCKG_SZ   = 40,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_pndng,
  input  logic [NUM_REQ*PCKG_SZ-1:0]   req_data,
  output logic [NUM_REQ-1:0]           req_pop,
  output logic [PCKG_SZ-1:0]           data_out_i_in,
  output logic                         pndng_i_in,
  input  logic                         popin,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]        grant_cnt
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gid_q, gid_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [PCKG_SZ-1:0]   data_q, data_d;

  logic                 grant_act;
  logic [IW-1:0]        grant_idx;
  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        cand;
  logic                 slot_free;
  logic                 load;

  // Round-robin search: first pending requester strictly after ptr_q, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_pndng[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    cnt_d     = cnt_q;
    grant_act = 1'b0;
    grant_idx = gid_q;
    slot_free = !valid_q || popin;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_act = 1'b1;
          grant_idx = win_idx;
          gid_d     = win_idx;
          cnt_d     = 8'd0;
          state_d   = BURST;
        end
      end
      BURST: begin
        // Release costs one bubble cycle: no load while handing back to IDLE.
        if (cnt_q == MAX_B || !req_pndng[gid_q]) begin
          ptr_d   = gid_q;
          state_d = IDLE;
        end else begin
          grant_act = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    load = grant_act && req_pndng[grant_idx] && slot_free;
    if (load) cnt_d = cnt_d + 8'd1;

    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = req_data[int'(grant_idx)*PCKG_SZ +: PCKG_SZ];
    end else if (popin) begin
      valid_d = 1'b0;
    end

    // Gated by reset so the strobe drops the instant reset asserts.
    req_pop = '0;
    if (load && !reset) req_pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      gid_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_out_i_in = data_q;
  assign pndng_i_in    = valid_q;
  assign grant_id      = gid_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (load && stat_q[grant_idx] != 16'hFFFF) begin
      stat_q[grant_idx] <= stat_q[grant_idx] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    assign grant_cnt[gi*16 +: 16] = stat_q[gi];
  end
`endif

endmodule
